// File: rtl/core_count_pkg.sv
// Shared definitions for the core_count family of counter cores:
// the FSM state encoding and the default counter width.
package core_count_pkg;

    localparam int unsigned COUNT_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/core_count8_add_sub.sv
// Registered increment cell: stores base, or base + 1 when en_n is low.
// The owner of this cell chooses base (current count, load value or zero).
module core_count8_add_sub #(
    parameter int unsigned Width = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             en_n,
    input  logic [Width-1:0] base,
    output logic [Width-1:0] count_q
);

    logic [Width-1:0] count_d;

    always_comb begin
        count_d = en_n ? base : base + Width'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/core_count8_add.sv
// Up-counter with IDLE/RUN/DONE control, synchronous load, terminal-count
// detection and registered oDone/oWrap pulses.
module core_count8_add
    import core_count_pkg::*;
#(
    parameter int unsigned CountWidth = COUNT_WIDTH_DEFAULT
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  _iEn,
    input  logic                  iStart,
    input  logic                  iLoad,
    input  logic [CountWidth-1:0] iCount,
    input  logic [CountWidth-1:0] iLimit,
    output logic [CountWidth-1:0] oCount,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oWrap
);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] base;
    logic                  inc_en_n;

    // NOTE: every always_comb output gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        base     = count_q;
        inc_en_n = 1'b1;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (iLoad) base = iCount;
                if (iStart) state_d = RUN;
            end
            RUN: begin
                if (iLoad) begin
                    base = iCount;
                end else if (!_iEn) begin
                    if (count_q == iLimit) begin
                        base    = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        inc_en_n = 1'b0;
                        wrap_d   = (count_q == {CountWidth{1'b1}});
                    end
                end
            end
            DONE: begin
                if (iLoad) base = iCount;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Busy is registered from the next state so it tracks state_q exactly.
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    core_count8_add_sub #(
        .Width (CountWidth)
    ) u_inc (
        .iClk    (iClk),
        .iRst    (iRst),
        .en_n    (inc_en_n),
        .base    (base),
        .count_q (count_q)
    );

    assign oCount = count_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oWrap  = wrap_q;

endmodule

// File: tb/tb_core_count8_add.sv
// Self-checking bench for core_count8_add: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_core_count8_add;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       en_n;
    logic       iStart;
    logic       iLoad;
    logic [7:0] iCount;
    logic [7:0] iLimit;
    logic [7:0] oCount;
    logic       oBusy;
    logic       oDone;
    logic       oWrap;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: "running" and "finishing" flags, integer count.
    int m_count;
    bit m_running;
    bit m_finishing;
    bit m_done;
    bit m_wrap;

    core_count8_add #(.CountWidth(8)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        ._iEn   (en_n),
        .iStart (iStart),
        .iLoad  (iLoad),
        .iCount (iCount),
        .iLimit (iLimit),
        .oCount (oCount),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oWrap  (oWrap)
    );

    always #5 iClk = ~iClk;

    task automatic model_edge();
        m_done = 1'b0;
        m_wrap = 1'b0;
        if (iRst) begin
            m_count     = 0;
            m_running   = 1'b0;
            m_finishing = 1'b0;
        end else if (m_finishing) begin
            m_finishing = 1'b0;
            if (iLoad) m_count = int'(iCount);
        end else if (!m_running) begin
            if (iLoad) m_count = int'(iCount);
            if (iStart) m_running = 1'b1;
        end else if (iLoad) begin
            m_count = int'(iCount);
        end else if (!en_n) begin
            if (m_count == int'(iLimit)) begin
                m_count     = 0;
                m_done      = 1'b1;
                m_running   = 1'b0;
                m_finishing = 1'b1;
            end else begin
                if (m_count == 255) m_wrap = 1'b1;
                m_count = (m_count + 1) % 256;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [10:0] observed;
        logic [10:0] expected;
        observed = {oCount, oBusy, oDone, oWrap};
        expected = {8'(m_count), m_running, m_done, m_wrap};
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed count=%02h busy=%0b done=%0b wrap=%0b, expected count=%02h busy=%0b done=%0b wrap=%0b",
                   tag, observed[10:3], observed[2], observed[1], observed[0],
                   expected[10:3], expected[2], expected[1], expected[0]);
        end
    endtask

    // Apply current inputs across one rising edge, then compare.
    task automatic cycle(input string tag);
        @(posedge iClk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic idle_inputs();
        iRst   = 1'b0;
        en_n   = 1'b1;
        iStart = 1'b0;
        iLoad  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        iCount = 8'h00;
        iLimit = 8'h00;
        m_count = 0; m_running = 0; m_finishing = 0; m_done = 0; m_wrap = 0;

        // Reset state
        iRst = 1'b1;
        cycle("reset");
        cycle("reset_hold");
        iRst = 1'b0;

        // Normal count to limit 3
        iLimit = 8'd3;
        iStart = 1'b1;
        cycle("norm_start");
        iStart = 1'b0;
        en_n   = 1'b0;
        for (int i = 0; i < 6; i++) cycle("norm_count");

        // Enable gating with limit 10
        en_n = 1'b1; iLimit = 8'd10; iStart = 1'b1;
        cycle("gate_start");
        iStart = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en_n = i[0];
            cycle("gate_toggle");
        end
        en_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("gate_hold");

        // Rollover: load FE, start, limit 01
        iRst = 1'b1; cycle("roll_reset"); iRst = 1'b0;
        iLoad = 1'b1; iCount = 8'hFE; iStart = 1'b1; iLimit = 8'h01;
        cycle("roll_load_start");
        iLoad = 1'b0; iStart = 1'b0; en_n = 1'b0;
        for (int i = 0; i < 5; i++) cycle("roll_seq");

        // Load priority at terminal count
        en_n = 1'b1; iLimit = 8'd5; iLoad = 1'b1; iCount = 8'd5; iStart = 1'b1;
        cycle("prio_setup");
        iLoad = 1'b1; iCount = 8'h20; iStart = 1'b0; en_n = 1'b0;
        cycle("prio_load");
        iLoad = 1'b0; en_n = 1'b1;
        cycle("prio_after");

        // Reset mid-RUN at count 7
        iRst = 1'b1; cycle("mid_pre_reset"); iRst = 1'b0;
        iLimit = 8'd20; iStart = 1'b1;
        cycle("mid_start");
        iStart = 1'b0; en_n = 1'b0;
        for (int i = 0; i < 7; i++) cycle("mid_count");
        iRst = 1'b1;
        cycle("mid_reset");
        iRst = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mid_no_resume");

        // Limit 0 with count 0
        iLimit = 8'd0; iStart = 1'b1; en_n = 1'b0;
        cycle("lim0_start");
        iStart = 1'b0;
        cycle("lim0_done");
        cycle("lim0_after");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            iRst   = ($urandom_range(0, 49) == 0);
            iLoad  = ($urandom_range(0, 9) == 0);
            iStart = ($urandom_range(0, 2) == 0);
            en_n   = ($urandom_range(0, 3) == 0);
            iCount = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(240, 255))
                                                 : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) iLimit = 8'($urandom_range(0, 20));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
